// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial unsigned a-b, one bit per clock (LSB first), with
//            busy/done handshake. SERIAL_SUBTRACTOR_SAT_EN clamps diff to 0
//            whenever the result borrows.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int                 c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_carry;
  logic               r_done;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;
  logic               w_nb;
  logic               w_sum;
  logic               w_cout;
  logic [WIDTH-1:0]   w_final;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt == c_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Subtraction as a + ~b + 1: the carry is seeded with 1 on accept.
  assign w_nb   = ~r_b[0];
  assign w_sum  = r_a[0] ^ w_nb ^ r_carry;
  assign w_cout = (r_a[0] & w_nb) | (r_carry & (r_a[0] ^ w_nb));

`ifdef SERIAL_SUBTRACTOR_SAT_EN
  assign w_final = r_carry ? r_res : '0;
`else
  assign w_final = r_res;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_cnt   <= '0;
            r_carry <= 1'b1;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= {w_sum, r_res[WIDTH-1:1]};
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
        end
        S_DONE: begin
          r_diff   <= w_final;
          r_borrow <= ~r_carry;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; the SHALL-support range is 2..16.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend; captured on accepted start.
REQ-006 Port: b  input  WIDTH  subtrahend; captured on accepted start.
REQ-007 Port: busy  output  1  high while the operation is in progress (RUN state).
REQ-008 Port: done  output  1  single-cycle pulse marking diff/borrow valid.
REQ-009 Port: diff  output  WIDTH  result a-b (mod 2^WIDTH, or saturated per REQ-026).
REQ-010 Port: borrow  output  1  high when a < b (unsigned).

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-012 In IDLE with start=1, the block SHALL capture a and b, clear the bit counter, and set the internal carry to 1; it SHALL then go to RUN.
REQ-013 In IDLE with start=0, the block SHALL remain in IDLE with outputs held.
REQ-014 In RUN, the block SHALL compute one bit per clock, LSB first, as a full-add of a[i], ~b[i], and carry; it SHALL shift the sum bit into the result and register the carry-out.
REQ-015 The bit counter SHALL increment each RUN cycle; after bit WIDTH-1 is processed, the FSM SHALL go to DONE.
REQ-016 In DONE, the block SHALL load diff and borrow (borrow = ~final carry), assert done for exactly one cycle, and return to IDLE.
REQ-017 Latency: with start accepted at edge k, done SHALL be high in the cycle after edge k+WIDTH+1, i.e. 9 edges after acceptance for WIDTH=8.
REQ-018 busy SHALL be 1 from the edge after acceptance through the last RUN cycle; busy and done SHALL never both be high.
REQ-019 start SHALL be ignored in RUN and DONE; no second capture and no queueing.
REQ-020 Changes on a or b after acceptance SHALL NOT affect the result.
REQ-021 diff and borrow SHALL hold their last values until the next DONE; they SHALL NOT show partial results during RUN.
REQ-022 Back-to-back operation: start asserted in the IDLE cycle right after DONE SHALL be accepted, giving one op per WIDTH+2 cycles.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, diff=0, borrow=0, clear the counter and carry.
REQ-024 rst SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse.
REQ-025 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Configuration
REQ-026 Macro SERIAL_SUBTRACTOR_SAT_EN: when defined, a result with borrow=1 SHALL present diff=0 while borrow still reads 1. When undefined, diff SHALL be the two's-complement wrap of a-b. Timing is identical in both builds.

Verification
REQ-027 a=0x50, b=0x20, start pulse -> done 9 edges later, diff=0x30, borrow=0, busy high for 8 cycles.
REQ-028 a=0x20, b=0x50 -> diff=0xD0, borrow=1; with SERIAL_SUBTRACTOR_SAT_EN, diff=0x00, borrow=1.
REQ-029 Edge operands: 0x00-0x00 -> 0x00/0; 0xFF-0x01 -> 0xFE/0; 0x00-0xFF -> 0x01/1 (SAT: 0x00/1); 0x80-0x80 -> 0x00/0.
REQ-030 Start 0x10-0x01, then re-pulse start with 0x00-0x05 mid-RUN and change a/b -> single done, diff=0x0F, borrow=0.
REQ-031 rst asserted at RUN bit 4 -> no done, all outputs 0 next cycle; then 0x09-0x03 -> diff=0x06 after 9 edges.
REQ-032 Back-to-back: start held high continuously -> done every 10 cycles, results match the operands captured at each accept.
